// File: rtl/retire_free_list.sv
// -----------------------------------------------------------------------------
// retire_free_list
//   Free list of physical register tags for a two-wide rename/retire pipeline.
//   Retiring instructions return their superseded physical tag to the tail of
//   a circular FIFO; rename pulls up to two tags per cycle from the head.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   ret0_valid     retire slot 0 valid (oldest)
//   ret0_rd        slot 0 new physical destination (interface only)
//   ret0_old_rd    slot 0 superseded physical destination, returned to list
//   ret1_valid     retire slot 1 valid (younger)
//   ret1_rd        slot 1 new physical destination (interface only)
//   ret1_old_rd    slot 1 superseded physical destination, returned to list
//   alloc_en0      rename consumes free_preg0 this cycle
//   alloc_en1      rename consumes free_preg1 this cycle
//   free_preg0     oldest free tag (head)
//   free_preg1     second-oldest free tag (head+1)
//   free_valid     bit i set when free_preg_i holds a real free tag
//   free_count     number of free tags held
//   rename_stall   fewer than two free tags available
//   retired_count  instructions retired since reset (wraps)
//   overflow_err   sticky: a returned tag was dropped because the list was full
//   underflow_err  sticky: an allocation request could not be honoured
// -----------------------------------------------------------------------------
module retire_free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ret0_valid,
    input  logic [$clog2(NUM_PREG)-1:0]         ret0_rd,
    input  logic [$clog2(NUM_PREG)-1:0]         ret0_old_rd,
    input  logic                                ret1_valid,
    input  logic [$clog2(NUM_PREG)-1:0]         ret1_rd,
    input  logic [$clog2(NUM_PREG)-1:0]         ret1_old_rd,
    input  logic                                alloc_en0,
    input  logic                                alloc_en1,
    output logic [$clog2(NUM_PREG)-1:0]         free_preg0,
    output logic [$clog2(NUM_PREG)-1:0]         free_preg1,
    output logic [1:0]                          free_valid,
    output logic [$clog2(NUM_PREG+1)-1:0]       free_count,
    output logic                                rename_stall,
    output logic [31:0]                         retired_count,
    output logic                                overflow_err,
    output logic                                underflow_err
);

    localparam int TAG_W = $clog2(NUM_PREG);
    localparam int CNT_W = $clog2(NUM_PREG + 1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_ZERO = {TAG_W{1'b0}};

    logic [TAG_W-1:0] mem_r [NUM_PREG];
    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      retired_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             pop0_s;
    logic             pop1_s;
    logic [1:0]       pops_s;
    logic             uflow_s;
    logic             push0_s;
    logic             push1_s;
    logic [1:0]       req_s;
    logic [1:0]       acc_s;
    logic             oflow_s;
    logic [CNT_W-1:0] space_s;
    logic [TAG_W-1:0] first_tag_s;
    logic [CNT_W-1:0] count_next_s;

    // Combinational read of the two oldest entries; no bypass of same-cycle pushes.
    always_comb begin
        free_preg0   = mem_r[head_r];
        free_preg1   = mem_r[head_r + TAG_ONE];
        free_valid   = {(count_r >= CNT_W'(2)), (count_r >= CNT_W'(1))};
        free_count   = count_r;
        rename_stall = (count_r < CNT_W'(2));
    end

    // Decide which allocation requests are honoured and flag the rest.
    always_comb begin
        pop0_s  = 1'b0;
        pop1_s  = 1'b0;
        uflow_s = 1'b0;
        if (alloc_en0 && free_valid[0]) begin
            pop0_s = 1'b1;
        end else begin
            pop0_s = 1'b0;
        end
        // Slot 1 can only be taken together with slot 0 so the head stays contiguous.
        if (alloc_en0 && alloc_en1 && free_valid[1]) begin
            pop1_s = 1'b1;
        end else begin
            pop1_s = 1'b0;
        end
        if ((alloc_en1 && !alloc_en0) || (alloc_en0 && !free_valid[0]) ||
            (alloc_en1 && !free_valid[1])) begin
            uflow_s = 1'b1;
        end else begin
            uflow_s = 1'b0;
        end
        pops_s = {1'b0, pop0_s} + {1'b0, pop1_s};
    end

    // Collect returned tags in age order and clip them to the room left after pops.
    always_comb begin
        push0_s     = ret0_valid && (ret0_old_rd != TAG_ZERO);
        push1_s     = ret1_valid && (ret1_old_rd != TAG_ZERO);
        req_s       = {1'b0, push0_s} + {1'b0, push1_s};
        // When slot 0 has nothing to return, slot 1 takes the tail position.
        first_tag_s = push0_s ? ret0_old_rd : ret1_old_rd;
        space_s     = CNT_W'(NUM_PREG) - count_r + CNT_W'(pops_s);
        if (CNT_W'(req_s) <= space_s) begin
            acc_s   = req_s;
            oflow_s = 1'b0;
        end else begin
            // Only reachable with space 0 or 1, so the low bits are exact.
            acc_s   = space_s[1:0];
            oflow_s = 1'b1;
        end
        count_next_s = count_r + CNT_W'(acc_s) - CNT_W'(pops_s);
    end

    // Tag storage: reset maps the non-architectural registers as free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                if (i < NUM_AREG) begin
                    mem_r[i] <= TAG_W'(NUM_AREG + i);
                end else begin
                    mem_r[i] <= TAG_ZERO;
                end
            end
        end else begin
            if (acc_s != 2'd0) begin
                mem_r[tail_r] <= first_tag_s;
            end
            if (acc_s == 2'd2) begin
                mem_r[tail_r + TAG_ONE] <= ret1_old_rd;
            end
        end
    end

    // Pointers, occupancy, retire counter and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r      <= TAG_ZERO;
            tail_r      <= TAG_W'(NUM_AREG);
            count_r     <= CNT_W'(NUM_PREG - NUM_AREG);
            retired_r   <= 32'd0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            head_r      <= head_r + TAG_W'(pops_s);
            tail_r      <= tail_r + TAG_W'(acc_s);
            count_r     <= count_next_s;
            retired_r   <= retired_r + {31'd0, ret0_valid} + {31'd0, ret1_valid};
            overflow_r  <= overflow_r | oflow_s;
            underflow_r <= underflow_r | uflow_s;
        end
    end

    assign retired_count = retired_r;
    assign overflow_err  = overflow_r;
    assign underflow_err = underflow_r;

endmodule

// File: tb/tb_retire_free_list.sv
// -----------------------------------------------------------------------------
// tb_retire_free_list
//   Directed self-checking bench for retire_free_list: reset state, dual
//   allocation, drain to empty and underflow, retire into an empty list,
//   x0 filtering, slot-1-only retire, FIFO order across pointer wrap,
//   fill to full with overflow, and asynchronous reset recovery.
// -----------------------------------------------------------------------------
module tb_retire_free_list;

    logic        tb_clk;
    logic        rst;
    logic        ret0_valid;
    logic [5:0]  ret0_rd;
    logic [5:0]  ret0_old_rd;
    logic        ret1_valid;
    logic [5:0]  ret1_rd;
    logic [5:0]  ret1_old_rd;
    logic        alloc_en0;
    logic        alloc_en1;
    logic [5:0]  free_preg0;
    logic [5:0]  free_preg1;
    logic [1:0]  free_valid;
    logic [6:0]  free_count;
    logic        rename_stall;
    logic [31:0] retired_count;
    logic        overflow_err;
    logic        underflow_err;

    int errors = 0;
    int checks = 0;

    retire_free_list #(.NUM_PREG(64), .NUM_AREG(32)) dut (
        .clk           (tb_clk),
        .rst           (rst),
        .ret0_valid    (ret0_valid),
        .ret0_rd       (ret0_rd),
        .ret0_old_rd   (ret0_old_rd),
        .ret1_valid    (ret1_valid),
        .ret1_rd       (ret1_rd),
        .ret1_old_rd   (ret1_old_rd),
        .alloc_en0     (alloc_en0),
        .alloc_en1     (alloc_en1),
        .free_preg0    (free_preg0),
        .free_preg1    (free_preg1),
        .free_valid    (free_valid),
        .free_count    (free_count),
        .rename_stall  (rename_stall),
        .retired_count (retired_count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic clear_inputs();
        ret0_valid  = 1'b0;
        ret0_rd     = 6'd0;
        ret0_old_rd = 6'd0;
        ret1_valid  = 1'b0;
        ret1_rd     = 6'd0;
        ret1_old_rd = 6'd0;
        alloc_en0   = 1'b0;
        alloc_en1   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_preg0"}, 32'(free_preg0), 32'd32);
        check_eq({tag, "_preg1"}, 32'(free_preg1), 32'd33);
        check_eq({tag, "_valid"}, 32'(free_valid), 32'd3);
        check_eq({tag, "_count"}, 32'(free_count), 32'd32);
        check_eq({tag, "_stall"}, 32'(rename_stall), 32'd0);
        check_eq({tag, "_retired"}, retired_count, 32'd0);
        check_eq({tag, "_oflow"}, 32'(overflow_err), 32'd0);
        check_eq({tag, "_uflow"}, 32'(underflow_err), 32'd0);
    endtask

    int first4 [4] = '{5, 9, 40, 7};

    initial begin
        int exp0;
        int exp1;
        clear_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        #10;
        check_reset_state("reset");
        @(posedge tb_clk);
        #1 rst = 1'b1;

        // Dual allocation out of the reset list.
        alloc_en0 = 1'b1;
        alloc_en1 = 1'b1;
        step();
        check_eq("dual_pop_preg0", 32'(free_preg0), 32'd34);
        check_eq("dual_pop_preg1", 32'(free_preg1), 32'd35);
        check_eq("dual_pop_count", 32'(free_count), 32'd30);

        // Drain the remaining 30 tags.
        for (int k = 0; k < 15; k++) step();
        clear_inputs();
        check_eq("drain_count", 32'(free_count), 32'd0);
        check_eq("drain_valid", 32'(free_valid), 32'd0);
        check_eq("drain_stall", 32'(rename_stall), 32'd1);
        check_eq("drain_uflow_clear", 32'(underflow_err), 32'd0);

        // Allocation from an empty list.
        alloc_en0 = 1'b1;
        step();
        clear_inputs();
        check_eq("empty_pop_uflow", 32'(underflow_err), 32'd1);
        check_eq("empty_pop_count", 32'(free_count), 32'd0);

        // Retire into the empty list while rename tries to allocate: no bypass.
        ret0_valid  = 1'b1;
        ret0_old_rd = 6'd5;
        ret0_rd     = 6'd20;
        ret1_valid  = 1'b1;
        ret1_old_rd = 6'd9;
        ret1_rd     = 6'd21;
        alloc_en0   = 1'b1;
        #1;
        check_eq("no_bypass_valid", 32'(free_valid), 32'd0);
        step();
        clear_inputs();
        check_eq("refill_preg0", 32'(free_preg0), 32'd5);
        check_eq("refill_preg1", 32'(free_preg1), 32'd9);
        check_eq("refill_count", 32'(free_count), 32'd2);
        check_eq("refill_retired", retired_count, 32'd2);

        // x0 mapping is retired but not returned.
        ret0_valid  = 1'b1;
        ret0_old_rd = 6'd0;
        ret1_valid  = 1'b1;
        ret1_old_rd = 6'd40;
        step();
        clear_inputs();
        check_eq("x0_count", 32'(free_count), 32'd3);
        check_eq("x0_retired", retired_count, 32'd4);
        check_eq("x0_preg0", 32'(free_preg0), 32'd5);

        // Slot 1 alone behaves as a single retire.
        ret1_valid  = 1'b1;
        ret1_old_rd = 6'd7;
        step();
        clear_inputs();
        check_eq("slot1_only_count", 32'(free_count), 32'd4);
        check_eq("slot1_only_retired", retired_count, 32'd5);

        // Steady one-in/one-out traffic; head and tail both cross 63 -> 0.
        for (int j = 0; j < 40; j++) begin
            exp0 = (j < 4) ? first4[j] : j - 3;
            exp1 = (j + 1 < 4) ? first4[j + 1] : j - 2;
            check_eq($sformatf("wrap_preg0_%0d", j), 32'(free_preg0), 32'(exp0));
            if (j % 8 == 0) begin
                check_eq($sformatf("wrap_preg1_%0d", j), 32'(free_preg1), 32'(exp1));
            end
            alloc_en0   = 1'b1;
            ret0_valid  = 1'b1;
            ret0_old_rd = 6'(j + 1);
            step();
        end
        clear_inputs();
        check_eq("wrap_count", 32'(free_count), 32'd4);
        check_eq("wrap_retired", retired_count, 32'd45);
        check_eq("wrap_tail_preg0", 32'(free_preg0), 32'd37);

        // Fill to capacity with dual retires.
        for (int j = 0; j < 30; j++) begin
            ret0_valid  = 1'b1;
            ret0_old_rd = 6'(2 * j + 1);
            ret1_valid  = 1'b1;
            ret1_old_rd = 6'(2 * j + 2);
            step();
        end
        clear_inputs();
        check_eq("full_count", 32'(free_count), 32'd64);
        check_eq("full_valid", 32'(free_valid), 32'd3);
        check_eq("full_oflow_clear", 32'(overflow_err), 32'd0);
        check_eq("full_uflow_sticky", 32'(underflow_err), 32'd1);
        check_eq("full_retired", retired_count, 32'd105);

        // Dual retire plus one pop on a full list: one tag accepted, one dropped.
        ret0_valid  = 1'b1;
        ret0_old_rd = 6'd11;
        ret1_valid  = 1'b1;
        ret1_old_rd = 6'd12;
        alloc_en0   = 1'b1;
        step();
        clear_inputs();
        check_eq("ovf_count", 32'(free_count), 32'd64);
        check_eq("ovf_flag", 32'(overflow_err), 32'd1);
        check_eq("ovf_preg0", 32'(free_preg0), 32'd38);
        check_eq("ovf_preg1", 32'(free_preg1), 32'd39);
        check_eq("ovf_retired", retired_count, 32'd107);

        // Asynchronous reset mid-operation, with requests still asserted.
        alloc_en0 = 1'b1;
        ret0_valid  = 1'b1;
        ret0_old_rd = 6'd3;
        rst = 1'b0;
        #2;
        check_reset_state("midrst");
        ret0_valid  = 1'b0;
        ret0_old_rd = 6'd0;
        rst = 1'b1;

        // First post-reset edge is an ordinary cycle.
        step();
        clear_inputs();
        check_eq("post_rst_preg0", 32'(free_preg0), 32'd33);
        check_eq("post_rst_count", 32'(free_count), 32'd31);

        // alloc_en1 without alloc_en0 is refused.
        alloc_en1 = 1'b1;
        step();
        clear_inputs();
        check_eq("en1_alone_uflow", 32'(underflow_err), 32'd1);
        check_eq("en1_alone_count", 32'(free_count), 32'd31);
        check_eq("en1_alone_preg0", 32'(free_preg0), 32'd33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/retire_free_list.md
RETIRE_FREE_LIST -- requirements
Module: retire_free_list

Interface
REQ-001 Parameter NUM_PREG, default 64: number of physical registers; tags are 6 bits wide.
REQ-002 Parameter NUM_AREG, default 32: number of architectural registers; physical registers 0..NUM_AREG-1 are mapped at reset.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ret0_valid  input  1  retire slot 0 carries a committed instruction (oldest).
REQ-006 ret0_rd, ret0_old_rd  input  6 each  new physical destination and superseded physical destination of slot 0.
REQ-007 ret1_valid, ret1_rd, ret1_old_rd  input  1/6/6  same as slot 0 for slot 1 (younger).
REQ-008 alloc_en0, alloc_en1  input  1 each  rename consumes free_preg0 / free_preg1 this cycle.
REQ-009 free_preg0, free_preg1  output  6 each  oldest and second-oldest free physical tags (head, head+1).
REQ-010 free_valid  output  2  bit i set when free_preg_i holds a real free tag.
REQ-011 free_count  output  7  number of free tags held, 0..64.
REQ-012 rename_stall  output  1  asserted when free_count < 2.
REQ-013 retired_count  output  32  total instructions retired since reset.
REQ-014 overflow_err, underflow_err  output  1 each  sticky error flags.

Function
REQ-015 Storage: a 64-entry circular FIFO of 6-bit tags with a 6-bit head pointer, a 6-bit tail pointer and a 7-bit count; both pointers wrap from 63 to 0.
REQ-016 Outputs free_preg0/1 and free_valid are combinational from head, count and FIFO contents: free_valid = {count>=2, count>=1}.
REQ-017 Pop: alloc_en0 is honoured only when free_valid[0]; alloc_en1 only when alloc_en0 and free_valid[1]; head advances by the number honoured (0, 1 or 2).
REQ-018 alloc_en1 without alloc_en0, or any alloc_en on an invalid slot, sets underflow_err; no pointer moves for the dishonoured request.
REQ-019 Push: retireN_valid with retN_old_rd != 0 pushes retN_old_rd at tail; slot 0 writes before slot 1, so with both pushing, slot 0 goes to tail and slot 1 to tail+1.
REQ-020 retN_old_rd == 0 (x0 mapping) is never pushed but still counts as retired.
REQ-021 retired_count increments by ret0_valid + ret1_valid each cycle and wraps modulo 2^32.
REQ-022 ret1_valid without ret0_valid is legal: it is treated as a single retire and pushed at tail.
REQ-023 Same-cycle push and pop: count_next = count + pushes - pops; a tag pushed this cycle is not visible on free_preg until the next cycle (no bypass), even when count is 0.
REQ-024 A push that would make count exceed 64 (after same-cycle pops) is dropped and sets overflow_err; pops in that cycle still complete.
REQ-025 The error flags clear only on reset.
REQ-026 ret*_rd is accepted for the interface contract only; it does not alter FIFO state.

Reset
REQ-027 While rst is low: entries i = 0..31 hold tag NUM_AREG+i (32..63); head = 0; tail = 32; count = 32; retired_count = 0; both error flags = 0.
REQ-028 Resulting outputs during reset: free_preg0 = 32, free_preg1 = 33, free_valid = 2'b11, free_count = 32, rename_stall = 0.
REQ-029 Reset asserted mid-operation discards all in-flight pushes and pops immediately; the first post-reset edge behaves as a normal cycle.

Verification
REQ-030 Reset, then alloc_en0 = alloc_en1 = 1 for 1 cycle -> free_preg0/1 = 34/35, free_count = 30.
REQ-031 Drain 32 tags (16 dual pops) -> free_count = 0, free_valid = 00, rename_stall = 1; a further alloc_en0 -> underflow_err = 1, count stays 0.
REQ-032 From empty, retire slot0 old_rd = 5 and slot1 old_rd = 9 with alloc_en0 = 1 in the same cycle -> alloc ignored (underflow_err = 1); next cycle free_preg0 = 5, free_preg1 = 9, free_count = 2, retired_count += 2.
REQ-033 Retire with ret0_old_rd = 0, ret1_old_rd = 40 -> only tag 40 enqueued; retired_count += 2.
REQ-034 Run pop/push traffic long enough for head and tail to pass 63 -> tags come out in FIFO order across the 63->0 wrap.
REQ-035 With count = 64, dual retire plus one pop -> one tag is accepted, one is dropped, overflow_err = 1, count = 64; then pulse rst low -> REQ-028 values restored.
